centroid_tracker: RTL and testbench

CENTROID_TRACKER -- requirements
Module: centroid_tracker

---
 rtl/centroid_tracker.sv | 146 ++++++++++++++
 tb/tb_centroid_tracker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/centroid_tracker.sv
// Moving-average line-centroid tracker with LOST/TRACK/COAST state machine.
// Optional error dead-zone enabled by defining CENTROID_TRACKER_DEADBAND_EN.
module centroid_tracker #(
  parameter int IMG_W       = 640,
  parameter int AVG_DEPTH   = 4,
  parameter int LOST_FRAMES = 8,
  parameter int DEADBAND    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         centroid_x,
  input  logic               line_valid,
  input  logic               line_lost,
  output logic [9:0]         smooth_x,
  output logic signed [10:0] error_x,
  output logic [1:0]         track_state,
  output logic               lost,
  output logic               out_valid
);

  localparam int         PTR_W      = $clog2(AVG_DEPTH);
  localparam int         SUM_W      = $clog2(AVG_DEPTH * (IMG_W - 1) + 1);
  localparam logic [9:0] CENTRE     = 10'(IMG_W / 2);
  localparam logic [9:0] X_MAX      = 10'(IMG_W - 1);
  localparam logic [7:0] MISS_LIMIT = 8'(LOST_FRAMES);

  if (AVG_DEPTH < 2 || AVG_DEPTH > 16 || (AVG_DEPTH & (AVG_DEPTH - 1)) != 0 ||
      LOST_FRAMES < 1 || LOST_FRAMES > 255 || DEADBAND < 0) begin : g_bad_params
    $error("centroid_tracker: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_LOST  = 2'b00,
    ST_TRACK = 2'b01,
    ST_COAST = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         miss_q, miss_d;
  logic [9:0]         hist_q [AVG_DEPTH];
  logic [9:0]         hist_d [AVG_DEPTH];
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [9:0]         smooth_q, smooth_d;
  logic signed [10:0] error_q, error_d;
  logic               valid_q, valid_d;

  logic [9:0]         xClamp;
  logic signed [10:0] diff;
  logic               enterLost;

  assign xClamp = (centroid_x > X_MAX) ? X_MAX : centroid_x;

  always_comb begin
    state_d   = state_q;
    miss_d    = miss_q;
    hist_d    = hist_q;
    sum_d     = sum_q;
    ptr_d     = ptr_q;
    smooth_d  = smooth_q;
    valid_d   = 1'b0;
    enterLost = 1'b0;

    if (line_valid) begin
      valid_d = 1'b1;
      if (!line_lost) begin
        // Reacquiring from LOST prefills the window so the average snaps to x.
        if (state_q == ST_LOST) begin
          for (int i = 0; i < AVG_DEPTH; i++) hist_d[i] = xClamp;
          sum_d = SUM_W'(xClamp) << PTR_W;
        end else begin
          sum_d         = sum_q + SUM_W'(xClamp) - SUM_W'(hist_q[ptr_q]);
          hist_d[ptr_q] = xClamp;
          ptr_d         = ptr_q + PTR_W'(1);
        end
        state_d  = ST_TRACK;
        miss_d   = 8'd0;
        smooth_d = 10'(sum_d >> PTR_W);
      end else begin
        unique case (state_q)
          ST_TRACK: begin
            if (LOST_FRAMES == 1) begin
              enterLost = 1'b1;
            end else begin
              state_d = ST_COAST;
              miss_d  = 8'd1;
            end
          end
          ST_COAST: begin
            if (miss_q + 8'd1 >= MISS_LIMIT) enterLost = 1'b1;
            else                             miss_d = miss_q + 8'd1;
          end
          default: ;
        endcase
        if (enterLost) begin
          state_d  = ST_LOST;
          miss_d   = 8'd0;
          smooth_d = CENTRE;
        end
      end
    end
  end

  // Error always follows the smoothed value, so holding smooth_x holds error_x too.
  always_comb begin
    diff = $signed({1'b0, smooth_d}) - $signed({1'b0, CENTRE});
`ifdef CENTROID_TRACKER_DEADBAND_EN
    begin
      logic [10:0] mag;
      mag = diff[10] ? 11'(-diff) : 11'(diff);
      error_d = (mag <= 11'(DEADBAND)) ? 11'sd0 : diff;
    end
`else
    error_d = diff;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOST;
      miss_q   <= 8'd0;
      for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= 10'd0;
      sum_q    <= '0;
      ptr_q    <= '0;
      smooth_q <= CENTRE;
      error_q  <= 11'sd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      miss_q   <= miss_d;
      hist_q   <= hist_d;
      sum_q    <= sum_d;
      ptr_q    <= ptr_d;
      smooth_q <= smooth_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
    end
  end

  assign smooth_x    = smooth_q;
  assign error_x     = error_q;
  assign track_state = state_q;
  assign lost        = (state_q == ST_LOST);
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Self-checking bench for centroid_tracker: directed vectors plus randomized traffic
// compared against a queue-based moving-average model.
module tb_centroid_tracker;

  localparam int IMG_W       = 640;
  localparam int AVG_DEPTH   = 4;
  localparam int LOST_FRAMES = 8;
  localparam int DEADBAND    = 8;
  localparam int CENTRE      = IMG_W / 2;

  logic               clk;
  logic               rst;
  logic [9:0]         centroid_x;
  logic               line_valid;
  logic               line_lost;
  logic [9:0]         smooth_x;
  logic signed [10:0] error_x;
  logic [1:0]         track_state;
  logic               lost;
  logic               out_valid;

  int testsRun;
  int failCount;
  bit armed;

  // Reference model: 0=LOST 1=TRACK 2=COAST, history kept oldest-first.
  int mState;
  int mMiss;
  int mHist[$];
  int expSmooth;
  int expErr;
  int expValid;

  centroid_tracker #(
    .IMG_W(IMG_W), .AVG_DEPTH(AVG_DEPTH), .LOST_FRAMES(LOST_FRAMES), .DEADBAND(DEADBAND)
  ) dut (
    .clk(clk), .rst(rst), .centroid_x(centroid_x), .line_valid(line_valid),
    .line_lost(line_lost), .smooth_x(smooth_x), .error_x(error_x),
    .track_state(track_state), .lost(lost), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int errorOf(input int s);
    int d;
    d = s - CENTRE;
`ifdef CENTROID_TRACKER_DEADBAND_EN
    if (d <= DEADBAND && d >= -DEADBAND) d = 0;
`endif
    return d;
  endfunction

  task automatic modelUpdate(input bit v, input bit l, input int x, input bit r);
    int xc;
    int sum;
    if (r) begin
      mState = 0; mMiss = 0; mHist.delete();
      expSmooth = CENTRE; expErr = 0; expValid = 0;
      return;
    end
    expValid = v;
    if (!v) return;
    if (!l) begin
      xc = (x > IMG_W - 1) ? IMG_W - 1 : x;
      if (mState == 0) begin
        mHist.delete();
        for (int i = 0; i < AVG_DEPTH; i++) mHist.push_back(xc);
      end else begin
        void'(mHist.pop_front());
        mHist.push_back(xc);
      end
      sum = 0;
      foreach (mHist[i]) sum += mHist[i];
      expSmooth = sum / AVG_DEPTH;
      mState = 1;
      mMiss = 0;
    end else if (mState != 0) begin
      mMiss++;
      if (mMiss >= LOST_FRAMES) begin
        mState = 0; mMiss = 0; expSmooth = CENTRE;
      end else begin
        mState = 2;
      end
    end
    expErr = errorOf(expSmooth);
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    logic signed [10:0] e;
    e = 11'(expErr);
    testsRun++;
    assert (smooth_x === 10'(expSmooth)) else begin
      failCount++;
      $error("[TB] FAIL smooth_x observed=%0d expected=%0d", smooth_x, expSmooth);
    end
    testsRun++;
    assert (error_x === e) else begin
      failCount++;
      $error("[TB] FAIL error_x observed=%0d expected=%0d", error_x, e);
    end
    testsRun++;
    assert (track_state === 2'(mState)) else begin
      failCount++;
      $error("[TB] FAIL track_state observed=%0d expected=%0d", track_state, mState);
    end
    testsRun++;
    assert (lost === (mState == 0)) else begin
      failCount++;
      $error("[TB] FAIL lost observed=%0b expected=%0b", lost, mState == 0);
    end
    testsRun++;
    assert (out_valid === 1'(expValid)) else begin
      failCount++;
      $error("[TB] FAIL out_valid observed=%0b expected=%0d", out_valid, expValid);
    end
  endtask

  // One clock of stimulus: check the previous cycle's result, then drive new inputs.
  task automatic applyStimulus(input bit v, input bit l, input int x, input bit r);
    @(negedge clk);
    if (armed) checkOutput();
    rst        = r;
    line_valid = v;
    line_lost  = l;
    centroid_x = 10'(x);
    modelUpdate(v, l, x, r);
    armed = 1'b1;
  endtask

  initial begin
    testsRun = 0; failCount = 0; armed = 1'b0;
    rst = 1'b1; line_valid = 1'b0; line_lost = 1'b0; centroid_x = '0;
    mState = 0; mMiss = 0; expSmooth = CENTRE; expErr = 0; expValid = 0;

    // Reset for two cycles, then idle and confirm reset values.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkValue("reset_smooth", smooth_x, 320);
    checkValue("reset_state", track_state, 0);

    // Acquire at 400 from LOST.
    applyStimulus(1, 0, 400, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("prefill_smooth", smooth_x, 400);
    checkValue("prefill_error", error_x, 80);
    checkValue("prefill_valid", out_valid, 1);

    // Converge toward 200: 350, 300, 250, 200.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 200, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("converge_smooth", smooth_x, 200);

    // Seven misses coast, the eighth loses the line.
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("coast_state", track_state, 2);
    checkValue("coast_hold", smooth_x, 200);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("lost_state", track_state, 0);
    checkValue("lost_smooth", smooth_x, 320);
    applyStimulus(1, 0, 100, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("reacquire_smooth", smooth_x, 100);

    // Clamp and back-to-back pulses.
    for (int i = 0; i < LOST_FRAMES; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 700, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("clamp_smooth", smooth_x, 639);
    checkValue("clamp_error", error_x, 319);
    applyStimulus(1, 0, 639, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("b2b_smooth", smooth_x, 479);

    // Small offset (dead-zone when enabled), then reset right after.
    for (int i = 0; i < LOST_FRAMES; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 325, 0);
    applyStimulus(0, 0, 0, 0);
`ifdef CENTROID_TRACKER_DEADBAND_EN
    checkValue("small_error", error_x, 0);
`else
    checkValue("small_error", error_x, 5);
`endif
    applyStimulus(1, 0, 500, 1);
    applyStimulus(0, 0, 0, 0);
    checkValue("rst_smooth", smooth_x, 320);
    checkValue("rst_valid", out_valid, 0);

    // Randomized traffic including back-to-back pulses and resets mid-stream.
    for (int i = 0; i < 600; i++) begin
      bit v, l, r;
      int x;
      v = ($urandom_range(0, 99) < 60);
      l = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 2);
      x = (($urandom_range(0, 9)) == 0) ? $urandom_range(640, 1023) : $urandom_range(0, 639);
      applyStimulus(v, l, x, r);
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
